// File: rtl/lane_channel_model.sv
// One-direction N-lane link channel: per-lane programmable delay and skew, lane enable/reversal,
// and single-beat drop injection for TS beats, rx-detect and electrical-idle-break levels.
module lane_channel_model #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned TS_W    = 128,
  parameter int unsigned AW      = 10,
  parameter int unsigned SKW     = 4,
  parameter int unsigned DEF_DLY = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [AW-1:0]         cfg_delay,
  input  logic [SKW-1:0]        cfg_skew,
  input  logic [LANES-1:0]      cfg_lane_en,
  input  logic                  cfg_reverse,
  input  logic [LANES-1:0]      inj_drop,
  input  logic [LANES*TS_W-1:0] in_ts,
  input  logic [LANES-1:0]      in_ts_vld,
  input  logic [LANES-1:0]      in_det,
  input  logic [LANES-1:0]      in_eidle_brk,
  output logic [LANES*TS_W-1:0] out_ts,
  output logic [LANES-1:0]      out_ts_vld,
  output logic [LANES-1:0]      out_det,
  output logic [LANES-1:0]      out_eidle_brk,
  output logic [LANES-1:0]      drop_ack,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + SKW + 4;
  localparam int unsigned EW    = TS_W + 3;

  // History entry layout: {ts, vld, det, brk}
  logic [EW-1:0] mem [LANES][DEPTH];

  logic [AW-1:0]               cfg_delay_q, cfg_delay_d;
  logic [SKW-1:0]              cfg_skew_q, cfg_skew_d;
  logic [LANES-1:0]            cfg_lane_en_q, cfg_lane_en_d;
  logic                        cfg_reverse_q, cfg_reverse_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [LANES-1:0][AW-1:0]    fill_q, fill_d;
  logic [LANES-1:0]            arm_q, arm_d;
  logic [LANES*TS_W-1:0]       out_ts_q, out_ts_d;
  logic [LANES-1:0]            out_ts_vld_q, out_ts_vld_d;
  logic [LANES-1:0]            out_det_q, out_det_d;
  logic [LANES-1:0]            out_eidle_brk_q, out_eidle_brk_d;
  logic [LANES-1:0]            drop_ack_q, drop_ack_d;
  logic                        busy_q, busy_d;

  logic [LANES-1:0][CW-1:0]    dly_raw;
  logic [LANES-1:0][AW-1:0]    dly;
  logic [LANES-1:0][AW-1:0]    rd_idx;
  logic [LANES-1:0][EW-1:0]    rd_entry;
  logic [LANES-1:0][EW-1:0]    wr_entry;
  logic [LANES-1:0]            drop_now;
  logic [LANES-1:0]            hist_ok;
  logic [LANES-1:0]            lane_vld;
  logic [LANES-1:0]            fill_lt;

  // Effective per-lane delay, saturated into [1, DEPTH-1]
  always_comb begin
    dly_raw = '0;
    dly     = '0;
    rd_idx  = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      dly_raw[l] = CW'(cfg_delay_q) + CW'(cfg_skew_q) * CW'(l);
      if (dly_raw[l] == '0) begin
        dly[l] = AW'(1);
      end else if (dly_raw[l] > CW'(DEPTH - 1)) begin
        dly[l] = AW'(DEPTH - 1);
      end else begin
        dly[l] = AW'(dly_raw[l]);
      end
      rd_idx[l] = wr_ptr_q - dly[l];
    end
  end

  always_comb begin
    rd_entry = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      rd_entry[l] = mem[l][rd_idx[l]];
    end
  end

  always_comb begin
    int src;
    cfg_delay_d     = cfg_delay_q;
    cfg_skew_d      = cfg_skew_q;
    cfg_lane_en_d   = cfg_lane_en_q;
    cfg_reverse_d   = cfg_reverse_q;
    wr_ptr_d        = wr_ptr_q + AW'(1);
    fill_d          = fill_q;
    arm_d           = arm_q;
    drop_ack_d      = '0;
    out_ts_d        = '0;
    out_ts_vld_d    = '0;
    out_det_d       = '0;
    out_eidle_brk_d = '0;
    busy_d          = 1'b0;
    wr_entry        = '0;
    drop_now        = '0;
    hist_ok         = '0;
    lane_vld        = '0;
    fill_lt         = '0;
    src             = 0;

    if (cfg_load) begin
      cfg_delay_d   = cfg_delay;
      cfg_skew_d    = cfg_skew;
      cfg_lane_en_d = cfg_lane_en;
      cfg_reverse_d = cfg_reverse;
    end

    for (int l = 0; l < int'(LANES); l++) begin
      // An arm takes effect in the same cycle it is requested
      drop_now[l] = (arm_q[l] | inj_drop[l]) & in_ts_vld[l] & ~cfg_load;
      if (cfg_load) begin
        arm_d[l] = 1'b0;
      end else if (drop_now[l]) begin
        arm_d[l]      = 1'b0;
        drop_ack_d[l] = 1'b1;
      end else if (inj_drop[l]) begin
        arm_d[l] = 1'b1;
      end

      if (cfg_lane_en_q[l]) begin
        wr_entry[l] = {in_ts[l*TS_W +: TS_W], in_ts_vld[l] & ~drop_now[l],
                       in_det[l], in_eidle_brk[l]};
      end

      if (cfg_load) begin
        fill_d[l] = '0;
      end else if (fill_q[l] < dly[l]) begin
        fill_d[l] = fill_q[l] + AW'(1);
      end
      fill_lt[l] = fill_d[l] < dly[l];

      hist_ok[l]  = fill_q[l] >= dly[l];
      lane_vld[l] = hist_ok[l] & rd_entry[l][2];
    end

    // Reversal is applied on the delayed lanes
    for (int j = 0; j < int'(LANES); j++) begin
      src = cfg_reverse_q ? (int'(LANES) - 1 - j) : j;
      out_ts_vld_d[j]    = lane_vld[src];
      out_det_d[j]       = hist_ok[src] & rd_entry[src][1];
      out_eidle_brk_d[j] = hist_ok[src] & rd_entry[src][0];
      if (lane_vld[src]) begin
        out_ts_d[j*TS_W +: TS_W] = rd_entry[src][EW-1:3];
      end
    end

    busy_d = |(cfg_lane_en_d & fill_lt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_delay_q     <= AW'(DEF_DLY);
      cfg_skew_q      <= '0;
      cfg_lane_en_q   <= '1;
      cfg_reverse_q   <= 1'b0;
      wr_ptr_q        <= '0;
      fill_q          <= '0;
      arm_q           <= '0;
      out_ts_q        <= '0;
      out_ts_vld_q    <= '0;
      out_det_q       <= '0;
      out_eidle_brk_q <= '0;
      drop_ack_q      <= '0;
      busy_q          <= 1'b0;
    end else begin
      cfg_delay_q     <= cfg_delay_d;
      cfg_skew_q      <= cfg_skew_d;
      cfg_lane_en_q   <= cfg_lane_en_d;
      cfg_reverse_q   <= cfg_reverse_d;
      wr_ptr_q        <= wr_ptr_d;
      fill_q          <= fill_d;
      arm_q           <= arm_d;
      out_ts_q        <= out_ts_d;
      out_ts_vld_q    <= out_ts_vld_d;
      out_det_q       <= out_det_d;
      out_eidle_brk_q <= out_eidle_brk_d;
      drop_ack_q      <= drop_ack_d;
      busy_q          <= busy_d;
    end
  end

  // History rings carry no reset; the fill counters mask stale entries
  always_ff @(posedge clk) begin
    for (int l = 0; l < int'(LANES); l++) begin
      mem[l][wr_ptr_q] <= wr_entry[l];
    end
  end

  assign out_ts        = out_ts_q;
  assign out_ts_vld    = out_ts_vld_q;
  assign out_det       = out_det_q;
  assign out_eidle_brk = out_eidle_brk_q;
  assign drop_ack      = drop_ack_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_lane_channel_model.sv
// Scoreboarded bench for lane_channel_model: directed beats push expected arrivals, a monitor
// pops and compares them whenever an output lane shows a valid beat.
module tb_lane_channel_model;

  localparam int LANES = 4;
  localparam int TS_W  = 128;
  localparam int AW    = 10;
  localparam int SKW   = 4;

  typedef struct {
    int              cyc;
    logic [TS_W-1:0] ts;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_load;
  logic [AW-1:0]         cfg_delay;
  logic [SKW-1:0]        cfg_skew;
  logic [LANES-1:0]      cfg_lane_en;
  logic                  cfg_reverse;
  logic [LANES-1:0]      inj_drop;
  logic [LANES*TS_W-1:0] in_ts;
  logic [LANES-1:0]      in_ts_vld;
  logic [LANES-1:0]      in_det;
  logic [LANES-1:0]      in_eidle_brk;
  logic [LANES*TS_W-1:0] out_ts;
  logic [LANES-1:0]      out_ts_vld;
  logic [LANES-1:0]      out_det;
  logic [LANES-1:0]      out_eidle_brk;
  logic [LANES-1:0]      drop_ack;
  logic                  busy;

  exp_t            exq [LANES][$];
  int              cyc;
  int              errors = 0;
  int              checks = 0;
  int              drop_cnt [LANES];
  exp_t            mon_e;
  logic [TS_W-1:0] mon_got;
  int              d2 [LANES] = '{20, 23, 26, 29};
  int              t0;

  lane_channel_model dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_load     (cfg_load),
    .cfg_delay    (cfg_delay),
    .cfg_skew     (cfg_skew),
    .cfg_lane_en  (cfg_lane_en),
    .cfg_reverse  (cfg_reverse),
    .inj_drop     (inj_drop),
    .in_ts        (in_ts),
    .in_ts_vld    (in_ts_vld),
    .in_det       (in_det),
    .in_eidle_brk (in_eidle_brk),
    .out_ts       (out_ts),
    .out_ts_vld   (out_ts_vld),
    .out_det      (out_det),
    .out_eidle_brk(out_eidle_brk),
    .drop_ack     (drop_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // cyc = number of active edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Monitor: consume expected beats as output lanes present them
  always @(negedge clk) begin
    if (rst) begin
      for (int j = 0; j < LANES; j++) begin
        mon_got = out_ts[j*TS_W +: TS_W];
        drop_cnt[j] = drop_cnt[j] + int'(drop_ack[j]);
        if (out_ts_vld[j]) begin
          checks++;
          if (exq[j].size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat lane=%0d cyc=%0d got=%h required=none", j, cyc, mon_got);
          end else begin
            mon_e = exq[j].pop_front();
            if (mon_e.cyc != cyc || mon_e.ts !== mon_got) begin
              errors++;
              $display("FAIL beat lane=%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                       j, cyc, mon_got, mon_e.cyc, mon_e.ts);
            end
          end
        end else begin
          checks++;
          if (mon_got !== '0) begin
            errors++;
            $display("FAIL ts_not_zero lane=%0d cyc=%0d got=%h required=0", j, cyc, mon_got);
          end
          if (exq[j].size() != 0 && exq[j][0].cyc <= cyc) begin
            checks++;
            errors++;
            mon_e = exq[j].pop_front();
            $display("FAIL missing_beat lane=%0d cyc=%0d got=none required cyc=%0d data=%h",
                     j, cyc, mon_e.cyc, mon_e.ts);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [TS_W-1:0] got, input logic [TS_W-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic load(input int d, input int s, input logic [LANES-1:0] en, input logic rv);
    cfg_delay   = AW'(d);
    cfg_skew    = SKW'(s);
    cfg_lane_en = en;
    cfg_reverse = rv;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
  endtask

  function automatic logic [TS_W-1:0] pat(input int l, input int tag);
    return {32'(tag), 32'(l), ~32'(tag), 32'hC0DE_0000 + 32'(l)};
  endfunction

  task automatic put(input int l, input logic [TS_W-1:0] d);
    in_ts[l*TS_W +: TS_W] = d;
    in_ts_vld[l]          = 1'b1;
  endtask

  // Beat driven now is sampled at edge cyc+1 and must appear after edge cyc+1+dly
  task automatic expect_beat(input int lo, input int dly, input logic [TS_W-1:0] d);
    exp_t e;
    e.cyc = cyc + 1 + dly;
    e.ts  = d;
    exq[lo].push_back(e);
  endtask

  task automatic idle();
    in_ts     = '0;
    in_ts_vld = '0;
  endtask

  initial begin
    rst = 1'b0; cfg_load = 1'b0; cfg_delay = '0; cfg_skew = '0; cfg_lane_en = '0;
    cfg_reverse = 1'b0; inj_drop = '0; in_ts = '0; in_ts_vld = '0; in_det = '0;
    in_eidle_brk = '0;
    for (int l = 0; l < LANES; l++) drop_cnt[l] = 0;
    repeat (3) tick();
    chk("rst_vld", TS_W'(out_ts_vld), '0);
    chk("rst_det_brk", TS_W'({out_det, out_eidle_brk}), '0);
    chk("rst_busy_ack", TS_W'({busy, drop_ack}), '0);
    chk("rst_ts", TS_W'(|out_ts), '0);
    rst = 1'b1;

    // Default delay 500: level in at edge 10, out at edge 510
    wait_cyc(9);   in_det = 4'b0001;
    wait_cyc(499); chk("busy_499", TS_W'(busy), TS_W'(1));
    wait_cyc(500); chk("busy_500", TS_W'(busy), TS_W'(0));
    wait_cyc(509); chk("det_509", TS_W'(out_det), TS_W'(4'b0000));
    wait_cyc(510); chk("det_510", TS_W'(out_det), TS_W'(4'b0001));
    in_det = '0;

    // Delay 20 + 3 per lane
    load(20, 3, 4'b1111, 1'b0);
    t0 = cyc;
    chk("busy_after_load", TS_W'(busy), TS_W'(1));
    wait_cyc(t0 + 28); chk("busy_fill28", TS_W'(busy), TS_W'(1));
    wait_cyc(t0 + 29); chk("busy_fill29", TS_W'(busy), TS_W'(0));
    for (int l = 0; l < LANES; l++) begin
      put(l, pat(l, 2));
      expect_beat(l, d2[l], pat(l, 2));
    end
    tick(); idle();
    wait_cyc(cyc + 35);

    // Reversal: out lane 3-l carries input lane l with lane l's delay
    load(20, 3, 4'b1111, 1'b1);
    wait_cyc(cyc + 35);
    for (int l = 0; l < LANES; l++) begin
      put(l, pat(l, 3));
      expect_beat(LANES - 1 - l, d2[l], pat(l, 3));
    end
    tick(); idle();
    wait_cyc(cyc + 35);

    // Lane 1 disconnected
    load(20, 3, 4'b1101, 1'b0);
    wait_cyc(cyc + 35);
    in_det = 4'b1111; in_eidle_brk = 4'b1111;
    for (int l = 0; l < LANES; l++) begin
      put(l, pat(l, 4));
      if (l != 1) expect_beat(l, d2[l], pat(l, 4));
    end
    tick(); idle();
    wait_cyc(cyc + 35);
    chk("det_lane_en", TS_W'(out_det), TS_W'(4'b1101));
    chk("brk_lane_en", TS_W'(out_eidle_brk), TS_W'(4'b1101));
    in_det = '0; in_eidle_brk = '0;
    wait_cyc(cyc + 35);
    chk("det_cleared", TS_W'(out_det), TS_W'(4'b0000));

    // Drop injection on lane 2 (delay 26) and arming-cycle drop on lane 0 (delay 20)
    inj_drop = 4'b0100; tick(); inj_drop = '0;
    put(2, pat(2, 51)); tick(); idle();
    chk("drop_ack_l2", TS_W'(drop_ack), TS_W'(4'b0100));
    put(2, pat(2, 52)); expect_beat(2, 26, pat(2, 52)); tick(); idle();
    chk("drop_ack_once", TS_W'(drop_ack), TS_W'(4'b0000));
    put(2, pat(2, 53)); expect_beat(2, 26, pat(2, 53));
    inj_drop = 4'b0001; put(0, pat(0, 54)); tick(); idle(); inj_drop = '0;
    chk("drop_ack_l0", TS_W'(drop_ack), TS_W'(4'b0001));
    put(0, pat(0, 55)); expect_beat(0, 20, pat(0, 55));
    inj_drop = 4'b0100; tick(); idle(); inj_drop = '0;
    chk("arm_only_no_ack", TS_W'(drop_ack), TS_W'(4'b0000));
    put(2, pat(2, 56)); tick(); idle();
    chk("drop_ack_l2_again", TS_W'(drop_ack), TS_W'(4'b0100));
    put(2, pat(2, 57)); expect_beat(2, 26, pat(2, 57)); tick(); idle();
    wait_cyc(cyc + 35);
    chk("drop_cnt", TS_W'({8'(drop_cnt[3]), 8'(drop_cnt[2]), 8'(drop_cnt[1]), 8'(drop_cnt[0])}),
        TS_W'(32'h0002_0001));

    // Large delay: every lane saturates at 1023
    load(1023, 15, 4'b1111, 1'b0);
    t0 = cyc;
    wait_cyc(t0 + 1022); chk("busy_1022", TS_W'(busy), TS_W'(1));
    wait_cyc(t0 + 1023); chk("busy_1023", TS_W'(busy), TS_W'(0));
    in_det = 4'b1111;
    put(3, pat(3, 6)); expect_beat(3, 1023, pat(3, 6));
    put(0, pat(0, 6)); expect_beat(0, 1023, pat(0, 6));
    tick(); idle();
    t0 = cyc;
    wait_cyc(t0 + 1022); chk("det_clamp_early", TS_W'(out_det), TS_W'(4'b0000));
    wait_cyc(t0 + 1023); chk("det_clamp", TS_W'(out_det), TS_W'(4'b1111));
    put(1, pat(1, 7)); tick(); idle();
    repeat (100) tick();

    // Asynchronous reset mid-flight; the in-flight lane-1 beat must never appear
    for (int l = 0; l < LANES; l++) exq[l].delete();
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", TS_W'(out_ts_vld), '0);
    chk("arst_det_brk", TS_W'({out_det, out_eidle_brk}), '0);
    chk("arst_busy_ack", TS_W'({busy, drop_ack}), '0);
    chk("arst_ts", TS_W'(|out_ts), '0);
    in_det = '0;
    repeat (3) tick();
    rst = 1'b1;
    wait_cyc(499);  chk("busy_post_rst", TS_W'(busy), TS_W'(1));
    wait_cyc(1100); chk("det_post_rst", TS_W'(out_det), TS_W'(4'b0000));

    for (int l = 0; l < LANES; l++) chk("leftover_beats", TS_W'(exq[l].size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout got=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
